// File: rtl/wb_fetch_arbiter.sv
// Two-master pipelined Wishbone arbiter. Instruction fetch (ins) and the data stage (dat)
// share one downstream port. Data wins by default, and a starvation counter protects fetch.
module wb_fetch_arbiter #(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned OUTS_MAX   = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        ins_cyc,
    input  logic        ins_stb,
    input  logic        ins_we,
    input  logic [3:0]  ins_sel,
    input  logic [31:0] ins_adr,
    input  logic [31:0] ins_wdat,
    output logic [31:0] ins_rdat,
    output logic        ins_ack,
    output logic        ins_stall,

    input  logic        dat_cyc,
    input  logic        dat_stb,
    input  logic        dat_we,
    input  logic [3:0]  dat_sel,
    input  logic [31:0] dat_adr,
    input  logic [31:0] dat_wdat,
    output logic [31:0] dat_rdat,
    output logic        dat_ack,
    output logic        dat_stall,

    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdat,
    input  logic [31:0] bus_rdat,
    input  logic        bus_ack,
    input  logic        bus_stall,

    output logic [1:0]  grant,
    output logic [3:0]  outstanding
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] OUTS_LIM   = 4'(OUTS_MAX);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_INS  = 2'b01,
        S_DAT  = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  starve_cnt;

    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [3:0]  own_sel;
    logic [31:0] own_adr;
    logic [31:0] own_wdat;
    logic        outs_full;
    logic        accept;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_nxt unassigned and infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ins_cyc && dat_cyc) begin
                    state_nxt = (starve_cnt >= STARVE_LIM) ? S_INS : S_DAT;
                end else if (ins_cyc) begin
                    state_nxt = S_INS;
                end else if (dat_cyc) begin
                    state_nxt = S_DAT;
                end
            end
            S_INS:   if (!ins_cyc) state_nxt = S_IDLE;
            S_DAT:   if (!dat_cyc) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign outs_full = (outstanding == OUTS_LIM);

    // Every bus output is decoded from the state register, so an asynchronous
    // reset releases the bus immediately, without waiting for a clock edge.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_sel  = '0;
        own_adr  = '0;
        own_wdat = '0;
        case (state)
            S_INS: begin
                own_cyc  = ins_cyc;
                own_stb  = ins_stb;
                own_we   = ins_we;
                own_sel  = ins_sel;
                own_adr  = ins_adr;
                own_wdat = ins_wdat;
            end
            S_DAT: begin
                own_cyc  = dat_cyc;
                own_stb  = dat_stb;
                own_we   = dat_we;
                own_sel  = dat_sel;
                own_adr  = dat_adr;
                own_wdat = dat_wdat;
            end
            default: ;
        endcase

        bus_cyc  = own_cyc;
        bus_stb  = own_cyc & own_stb & ~outs_full;
        bus_we   = own_we;
        bus_sel  = own_sel;
        bus_adr  = own_adr;
        bus_wdat = own_wdat;

        // Acks are forwarded only to an owner that still holds cyc, so acks
        // belonging to a flushed cycle, or arriving while idle, are dropped.
        ins_ack   = (state == S_INS) & ins_cyc & bus_ack;
        ins_stall = (state != S_INS) | bus_stall | outs_full;
        dat_ack   = (state == S_DAT) & dat_cyc & bus_ack;
        dat_stall = (state != S_DAT) | bus_stall | outs_full;
        ins_rdat  = bus_rdat;
        dat_rdat  = bus_rdat;
    end

    assign grant  = state;
    assign accept = bus_stb & ~bus_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else if (!own_cyc) begin
            outstanding <= '0;
        end else begin
            case ({accept, bus_ack})
                2'b10:   if (!outs_full) outstanding <= outstanding + 4'd1;
                2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (state == S_IDLE && state_nxt == S_INS) begin
            starve_cnt <= '0;
        end else if (ins_cyc && state != S_INS && starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_wb_fetch_arbiter.sv
// Self-checking bench for wb_fetch_arbiter: a per-cycle behavioural model of the
// arbitration rules plus directed scenarios with hand-computed expectations.
module tb_wb_fetch_arbiter;

    localparam int STARVE_MAX = 8;
    localparam int OUTS_MAX   = 15;

    logic        clk;
    logic        rst;
    logic        ins_cyc, ins_stb, ins_we;
    logic [3:0]  ins_sel;
    logic [31:0] ins_adr, ins_wdat, ins_rdat;
    logic        ins_ack, ins_stall;
    logic        dat_cyc, dat_stb, dat_we;
    logic [3:0]  dat_sel;
    logic [31:0] dat_adr, dat_wdat, dat_rdat;
    logic        dat_ack, dat_stall;
    logic        bus_cyc, bus_stb, bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_adr, bus_wdat, bus_rdat;
    logic        bus_ack, bus_stall;
    logic [1:0]  grant;
    logic [3:0]  outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: owner 0 = none, 1 = ins, 2 = dat.
    int m_own    = 0;
    int m_outs   = 0;
    int m_starve = 0;

    wb_fetch_arbiter #(.STARVE_MAX(STARVE_MAX), .OUTS_MAX(OUTS_MAX)) dut (
        .clk_i(clk), .rst_i(rst),
        .ins_cyc(ins_cyc), .ins_stb(ins_stb), .ins_we(ins_we), .ins_sel(ins_sel),
        .ins_adr(ins_adr), .ins_wdat(ins_wdat), .ins_rdat(ins_rdat),
        .ins_ack(ins_ack), .ins_stall(ins_stall),
        .dat_cyc(dat_cyc), .dat_stb(dat_stb), .dat_we(dat_we), .dat_sel(dat_sel),
        .dat_adr(dat_adr), .dat_wdat(dat_wdat), .dat_rdat(dat_rdat),
        .dat_ack(dat_ack), .dat_stall(dat_stall),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
        .bus_adr(bus_adr), .bus_wdat(bus_wdat), .bus_rdat(bus_rdat),
        .bus_ack(bus_ack), .bus_stall(bus_stall),
        .grant(grant), .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic ic, input logic is, input logic dc, input logic ds,
                          input logic ack, input logic stl);
        ins_cyc   = ic;
        ins_stb   = is;
        dat_cyc   = dc;
        dat_stb   = ds;
        bus_ack   = ack;
        bus_stall = stl;
        bus_rdat  = $urandom;
        #1;
    endtask

    // Cycle model, evaluated on the falling edge while inputs are stable.
    always @(negedge clk) begin : compare
        logic        own_cyc, own_stb, own_we, full, e_stb;
        logic [3:0]  own_sel;
        logic [31:0] own_adr, own_wdat;
        int          nxt, outs_n;
        if (rst) begin
            m_own = 0; m_outs = 0; m_starve = 0;
            check("rst_grant", 64'(grant), 64'(2'b00));
            check("rst_outstanding", 64'(outstanding), 64'(4'd0));
            check("rst_bus_ctl", 64'({bus_cyc, bus_stb, bus_we, bus_sel}), 64'(7'd0));
            check("rst_bus_adr", 64'(bus_adr), 64'(32'd0));
            check("rst_bus_wdat", 64'(bus_wdat), 64'(32'd0));
            check("rst_resp", 64'({ins_ack, ins_stall, dat_ack, dat_stall}), 64'(4'b0101));
        end else begin
            own_cyc = 1'b0; own_stb = 1'b0; own_we = 1'b0;
            own_sel = '0; own_adr = '0; own_wdat = '0;
            if (m_own == 1) begin
                own_cyc = ins_cyc; own_stb = ins_stb; own_we = ins_we;
                own_sel = ins_sel; own_adr = ins_adr; own_wdat = ins_wdat;
            end else if (m_own == 2) begin
                own_cyc = dat_cyc; own_stb = dat_stb; own_we = dat_we;
                own_sel = dat_sel; own_adr = dat_adr; own_wdat = dat_wdat;
            end
            full  = (m_outs == OUTS_MAX);
            e_stb = own_cyc && own_stb && !full;

            check("grant", 64'(grant),
                  64'((m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00));
            check("outstanding", 64'(outstanding), 64'(m_outs));
            check("bus_ctl", 64'({bus_cyc, bus_stb, bus_we, bus_sel}),
                  64'({own_cyc, e_stb, own_we, own_sel}));
            check("bus_adr", 64'(bus_adr), 64'(own_adr));
            check("bus_wdat", 64'(bus_wdat), 64'(own_wdat));
            check("ins_resp", 64'({ins_ack, ins_stall}),
                  64'({(m_own == 1) && ins_cyc && bus_ack, (m_own != 1) || bus_stall || full}));
            check("dat_resp", 64'({dat_ack, dat_stall}),
                  64'({(m_own == 2) && dat_cyc && bus_ack, (m_own != 2) || bus_stall || full}));
            if (m_own == 1) check("ins_rdat", 64'(ins_rdat), 64'(bus_rdat));
            if (m_own == 2) check("dat_rdat", 64'(dat_rdat), 64'(bus_rdat));

            if (m_own == 0) begin
                if (ins_cyc && dat_cyc) nxt = (m_starve >= STARVE_MAX) ? 1 : 2;
                else if (ins_cyc)       nxt = 1;
                else if (dat_cyc)       nxt = 2;
                else                    nxt = 0;
            end else begin
                nxt = own_cyc ? m_own : 0;
            end

            if (m_own == 0 || !own_cyc) begin
                outs_n = 0;
            end else begin
                outs_n = m_outs + ((e_stb && !bus_stall) ? 1 : 0) - (bus_ack ? 1 : 0);
                if (outs_n < 0) outs_n = 0;
                if (outs_n > OUTS_MAX) outs_n = OUTS_MAX;
            end

            if (m_own == 0 && nxt == 1) m_starve = 0;
            else if (ins_cyc && m_own != 1 && m_starve < STARVE_MAX) m_starve = m_starve + 1;

            m_own  = nxt;
            m_outs = outs_n;
        end
    end

    initial begin
        rst = 1'b1;
        ins_cyc = 0; ins_stb = 0; ins_we = 1'b0; ins_sel = 4'hf;
        ins_adr = 32'h0000_1000; ins_wdat = 32'h0;
        dat_cyc = 0; dat_stb = 0; dat_we = 1'b1; dat_sel = 4'h3;
        dat_adr = 32'h8000_0040; dat_wdat = 32'hdead_beef;
        bus_rdat = 32'h0; bus_ack = 0; bus_stall = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", 64'(grant), 64'(2'b00));
        check("reset_outstanding", 64'(outstanding), 64'(4'd0));
        check("reset_bus_cyc", 64'(bus_cyc), 64'(1'b0));
        check("reset_resp", 64'({ins_ack, ins_stall, dat_ack, dat_stall}), 64'(4'b0101));
        rst = 1'b0;

        // ins only: one request, ack one cycle later
        set_in(1, 1, 0, 0, 0, 0);
        check("t1_first_stall", 64'(ins_stall), 64'(1'b1));
        check("t1_idle_grant", 64'(grant), 64'(2'b00));
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        check("t1_grant", 64'(grant), 64'(2'b01));
        check("t1_adr", 64'(bus_adr), 64'(32'h0000_1000));
        check("t1_stall", 64'(ins_stall), 64'(1'b0));
        tick();
        set_in(1, 0, 0, 0, 1, 0);
        check("t1_outs1", 64'(outstanding), 64'(4'd1));
        check("t1_ack", 64'(ins_ack), 64'(1'b1));
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        check("t1_outs0", 64'(outstanding), 64'(4'd0));
        tick();

        // simultaneous request: data wins, one idle gap before fetch
        set_in(1, 1, 1, 1, 0, 0);
        tick();
        set_in(1, 1, 1, 1, 0, 0);
        check("t2_grant", 64'(grant), 64'(2'b10));
        check("t2_ins_stall", 64'(ins_stall), 64'(1'b1));
        check("t2_dat_stall", 64'(dat_stall), 64'(1'b0));
        tick();
        set_in(1, 1, 1, 0, 1, 0);
        check("t2_dat_ack", 64'(dat_ack), 64'(1'b1));
        check("t2_ins_ack", 64'(ins_ack), 64'(1'b0));
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        check("t2_grant_hold", 64'(grant), 64'(2'b10));
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        check("t2_gap_cyc", 64'(bus_cyc), 64'(1'b0));
        check("t2_gap_grant", 64'(grant), 64'(2'b00));
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        check("t2_ins_grant", 64'(grant), 64'(2'b01));
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();

        // starvation: three data bursts of 3 denied cycles each, then fetch wins
        for (int b = 0; b < 3; b++) begin
            set_in(1, 1, 1, 0, 0, 0);
            tick();
            set_in(1, 1, 1, 0, 0, 0);
            check("t3_denied", 64'(grant), 64'(2'b10));
            tick();
            set_in(1, 1, 0, 0, 0, 0);
            tick();
        end
        set_in(1, 1, 1, 0, 0, 0);
        tick();
        check("t3_ins_wins", 64'(grant), 64'(2'b01));
        check("t3_dat_stall", 64'(dat_stall), 64'(1'b1));
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // pipelined data burst: 4 strobes, acks 3 cycles late
        set_in(1, 0, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 1, 0, 0);
            tick();
        end
        set_in(1, 0, 1, 1, 1, 0);
        check("t4_peak", 64'(outstanding), 64'(4'd3));
        check("t4_dat_ack", 64'(dat_ack), 64'(1'b1));
        check("t4_ins_ack", 64'(ins_ack), 64'(1'b0));
        check("t4_ins_stall", 64'(ins_stall), 64'(1'b1));
        tick();
        set_in(1, 0, 1, 0, 1, 0);
        tick();
        set_in(1, 0, 1, 0, 1, 0);
        tick();
        set_in(1, 0, 1, 0, 1, 0);
        check("t4_outs1", 64'(outstanding), 64'(4'd1));
        tick();
        set_in(1, 0, 0, 0, 0, 0);
        check("t4_drain", 64'(outstanding), 64'(4'd0));
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        check("t4_ins_grant", 64'(grant), 64'(2'b01));
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        tick();

        // flush with two requests in flight, then stray acks
        set_in(0, 0, 0, 0, 0, 0);
        check("t5_outs2", 64'(outstanding), 64'(4'd2));
        tick();
        set_in(0, 0, 0, 0, 1, 0);
        check("t5_stray_acks", 64'({ins_ack, dat_ack}), 64'(2'b00));
        check("t5_idle", 64'(grant), 64'(2'b00));
        check("t5_outs0", 64'(outstanding), 64'(4'd0));
        tick();
        set_in(0, 0, 0, 0, 1, 0);
        check("t5_stray_ack2", 64'(ins_ack), 64'(1'b0));
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();

        // slave stall, underflow clamp, saturation at OUTS_MAX
        set_in(0, 0, 1, 1, 0, 1);
        tick();
        set_in(0, 0, 1, 1, 0, 1);
        check("t7_stall_pass", 64'(dat_stall), 64'(1'b1));
        tick();
        check("t7_no_accept", 64'(outstanding), 64'(4'd0));
        set_in(0, 0, 1, 0, 1, 0);
        tick();
        check("t7_underflow", 64'(outstanding), 64'(4'd0));
        for (int i = 0; i < 15; i++) begin
            set_in(0, 0, 1, 1, 0, 0);
            tick();
        end
        check("t7_sat", 64'(outstanding), 64'(4'd15));
        set_in(0, 0, 1, 1, 0, 0);
        check("t7_full_stall", 64'(dat_stall), 64'(1'b1));
        check("t7_full_stb", 64'(bus_stb), 64'(1'b0));
        tick();
        check("t7_sat_hold", 64'(outstanding), 64'(4'd15));
        set_in(0, 0, 1, 1, 1, 0);
        tick();
        check("t7_ack_dec", 64'(outstanding), 64'(4'd14));
        set_in(0, 0, 1, 1, 0, 0);
        check("t7_reopen", 64'(dat_stall), 64'(1'b0));
        tick();

        // asynchronous reset in the middle of a burst
        rst = 1'b1;
        #1;
        check("t6_bus_cyc", 64'(bus_cyc), 64'(1'b0));
        check("t6_grant", 64'(grant), 64'(2'b00));
        check("t6_outs", 64'(outstanding), 64'(4'd0));
        check("t6_dat_stall", 64'(dat_stall), 64'(1'b1));
        tick();
        rst = 1'b0;
        set_in(0, 0, 1, 1, 0, 0);
        tick();
        check("t6_resume", 64'(grant), 64'(2'b10));
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
